rot_bin_table_gen: RTL
======================

// Module: rot_bin_table_gen
// PURPOSE
// - Generates the 256-entry rotated-coordinate bin table (16x16 patch -> 5-bit signed bin) for one
//   descriptor orientation and writes it into a 256x5 distributed RAM, which the descriptor datapath
//   then reads. Replaces one fixed ROM per orientation with a single generator driven per orientation.
// - Entry(r,c) = floor((ORIGIN + r*ROW_STEP + c*COL_STEP) / 2^FRAC), wrapped to 5 bits; addr = {r[3:0],c[3:0]}.
// PARAMETERS
// - FRAC    8   fractional bits of origin/step fixed-point values
// - ACC_W   16  signed accumulator width (bits)
// - DATA_W  5   table entry width; entry = acc[FRAC+DATA_W-1:FRAC]
// PORTS
// - clk         in   1      clock; all logic on rising edge
// - rst         in   1      synchronous reset, active-high
// - start       in   1      pulse: latch step inputs and begin generation (ignored while busy)
// - origin      in   ACC_W  signed Q.FRAC value of entry (0,0)
// - row_step    in   ACC_W  signed Q.FRAC increment per row (r)
// - col_step    in   ACC_W  signed Q.FRAC increment per column (c)
// - busy        out  1      high from cycle after accepted start until done
// - done        out  1      one-cycle pulse after last write accepted
// - wr_en       out  1      write request to table RAM
// - wr_addr     out  8      {row,col}
// - wr_data     out  DATA_W entry value (two's complement, wraps mod 2^DATA_W)
// - wr_ready    in   1      RAM/arbiter accepts write this cycle
// BEHAVIOUR
// - Reset: busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0; FSM->IDLE; step registers cleared.
// - FSM: IDLE -(start)-> RUN -(write 255 accepted)-> DONE -(1 cycle)-> IDLE.
// - start in IDLE at edge t: origin/row_step/col_step latched; row_acc=acc=origin; RUN at t+1 with
//   wr_en=1, wr_addr=0, wr_data=entry(0,0).
// - Handshake: write accepted on edge where wr_en&&wr_ready. While wr_en&&!wr_ready, wr_addr/wr_data
//   held stable. No combinational path wr_ready->wr_en.
// - On accept: addr+1; if col!=15 acc+=col_step; else row_acc+=row_step, acc=row_acc+row_step.
//   wr_ready tied high -> 256 writes on 256 consecutive cycles, done pulse on cycle 257 after start.
// - Last accept (addr 255): wr_en=0 next cycle, done=1 for that one cycle, busy=0 in the same cycle.
// - start while busy or in DONE: ignored; latched steps unchanged. start in IDLE the cycle after done: accepted.
// - Accumulator arithmetic: ACC_W two's complement, wraps silently; floor = arithmetic shift right
//   (bit-slice of acc), no rounding.
// - Reset mid-run: abort immediately, no further writes; table contents partially written (caller re-runs).
// - Inputs origin/row_step/col_step sampled only on accepted start; later changes have no effect.
// STRUCTURE
// - Package sift_rot_pkg: GRID=16, FRAC, DATA_W, ACC_W constants; FSM state encoding (IDLE/RUN/DONE).
// - Single module; no sub-module (row/col counter = 8-bit addr register, two accumulators, 3-state FSM).
// TESTING
// - Golden model: integer floor formula in bench; compare every write (addr,data) and count = 256.
// - 30-deg orientation: origin=878, row_step=128, col_step=-222, wr_ready=1 -> addr0=5'h03, addr4=5'h1f,
//   addr16=5'h03, addr32=5'h04, addr240=5'h0a, addr255=5'h1d; done exactly 257 cycles after start.
// - Backpressure: wr_ready random 50% -> addr/data stable while stalled, sequence identical to no-stall run.
// - start asserted again at cycle 100 of run with different steps -> ignored; output unchanged; one done.
// - rst asserted at addr 37 -> next cycle wr_en=0, busy=0, done=0; new start regenerates from addr 0.
// - Wrap: origin=16<<8, col_step=256, row_step=0 -> addr0=5'h10, addr15=5'h1f, addr16=5'h10 (mod-32 wrap).

Source files
------------

// File: rtl/sift_rot_pkg.sv
// ---------------------------------------------------------------------------
// sift_rot_pkg
// Shared constants and FSM encoding for the rotated-coordinate bin table
// generator.
//   GRID    : patch edge length (16x16 patch -> 256 table entries)
//   FRAC    : fractional bits of the origin/step fixed-point values
//   DATA_W  : table entry width (two's complement, wraps mod 2^DATA_W)
//   ACC_W   : signed accumulator width
//   COL_W   : bits needed for one coordinate (row or column)
//   ADDR_W  : table address width, address = {row, col}
// ---------------------------------------------------------------------------
package sift_rot_pkg;

  localparam int GRID   = 16;
  localparam int FRAC   = 8;
  localparam int DATA_W = 5;
  localparam int ACC_W  = 16;
  localparam int COL_W  = $clog2(GRID);
  localparam int ADDR_W = 2 * COL_W;

  // Column index of the last entry in a row, and address of the last entry.
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(GRID - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GRID * GRID - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rot_bin_table_gen.sv
// ---------------------------------------------------------------------------
// rot_bin_table_gen
// Fills a 256 x DATA_W table RAM with the bin index of every pixel of a
// 16x16 patch for one descriptor orientation:
//   entry(r,c) = floor((origin + r*row_step + c*col_step) / 2^FRAC) mod 2^DATA_W
//   address    = {r[3:0], c[3:0]}
// The products are never formed: one accumulator walks along the row by
// col_step, a second one remembers the start of the current row and steps by
// row_step when the column wraps.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous reset, active-high
//   start     in   pulse in IDLE: latch origin/steps and begin generation
//   origin    in   ACC_W  signed Q.FRAC value of entry (0,0)
//   row_step  in   ACC_W  signed Q.FRAC increment per row
//   col_step  in   ACC_W  signed Q.FRAC increment per column
//   busy      out  high while writes are being issued
//   done      out  one-cycle pulse after the last write is accepted
//   wr_en     out  write request to the table RAM
//   wr_addr   out  ADDR_W {row, col}
//   wr_data   out  DATA_W entry value
//   wr_ready  in   RAM/arbiter accepts the write this cycle
// ---------------------------------------------------------------------------
module rot_bin_table_gen
  import sift_rot_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ACC_W-1:0]  origin,
  input  logic [ACC_W-1:0]  row_step,
  input  logic [ACC_W-1:0]  col_step,
  output logic              busy,
  output logic              done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready
);

  state_t              r_state;
  state_t              w_state_nxt;

  logic [ADDR_W-1:0]   r_addr;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    r_row_acc;
  logic [ACC_W-1:0]    r_row_step;
  logic [ACC_W-1:0]    r_col_step;
  logic                r_busy;
  logic                r_done;
  logic                r_wr_en;

  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [ACC_W-1:0]    w_acc_nxt;
  logic [ACC_W-1:0]    w_row_acc_nxt;
  logic [ACC_W-1:0]    w_row_step_nxt;
  logic [ACC_W-1:0]    w_col_step_nxt;
  logic [ACC_W-1:0]    w_next_row_start;
  logic                w_accept;
  logic                w_last_col;
  logic                w_last_addr;

  // wr_en is a register, so wr_ready only ever reaches the next-state logic.
  assign w_accept         = r_wr_en & wr_ready;
  assign w_last_col       = (r_addr[COL_W-1:0] == LAST_COL);
  assign w_last_addr      = (r_addr == LAST_ADDR);
  assign w_next_row_start = r_row_acc + r_row_step;

  // Next-state, address and accumulator logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_acc_nxt      = r_acc;
    w_row_acc_nxt  = r_row_acc;
    w_row_step_nxt = r_row_step;
    w_col_step_nxt = r_col_step;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt    = ST_RUN;
          w_addr_nxt     = {ADDR_W{1'b0}};
          w_acc_nxt      = origin;
          w_row_acc_nxt  = origin;
          w_row_step_nxt = row_step;
          w_col_step_nxt = col_step;
        end else begin
          w_state_nxt    = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (w_accept) begin
          // Address wraps 255 -> 0 on the final accept; harmless since the
          // FSM leaves RUN on that same edge.
          w_addr_nxt = r_addr + ADDR_W'(1);
          if (w_last_col) begin
            // Next row: restart from the saved row origin plus one row step.
            w_row_acc_nxt = w_next_row_start;
            w_acc_nxt     = w_next_row_start;
          end else begin
            w_acc_nxt     = r_acc + r_col_step;
          end
          if (w_last_addr) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          // Stalled: everything holds so wr_addr/wr_data stay stable.
          w_state_nxt = ST_RUN;
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers and registered status outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= {ADDR_W{1'b0}};
      r_acc      <= {ACC_W{1'b0}};
      r_row_acc  <= {ACC_W{1'b0}};
      r_row_step <= {ACC_W{1'b0}};
      r_col_step <= {ACC_W{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wr_en    <= 1'b0;
    end else begin
      r_addr     <= w_addr_nxt;
      r_acc      <= w_acc_nxt;
      r_row_acc  <= w_row_acc_nxt;
      r_row_step <= w_row_step_nxt;
      r_col_step <= w_col_step_nxt;
      r_busy     <= (w_state_nxt == ST_RUN);
      r_done     <= (w_state_nxt == ST_DONE);
      r_wr_en    <= (w_state_nxt == ST_RUN);
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_addr;
  // Floor division by 2^FRAC is just the bit slice of the two's complement value.
  assign wr_data = r_acc[FRAC+DATA_W-1:FRAC];

endmodule
